// File: rtl/mac16_q9_pkg.sv
// Shared types and constants for the Q9 sequential dot-product engine.
// Holds fixed widths, Q9 clamp limits, data typedefs and the control FSM states.
package mac16_q9_pkg;

    localparam int Q9_FRAC = 9;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 36;

    typedef logic signed [DATA_W-1:0] q9_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam q9_t Q9_MAX = 16'sh7FFF;
    localparam q9_t Q9_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_e;

    // Sign-extend a Q9 value into the Q18 accumulator format.
    function automatic acc_t q9_to_acc(input q9_t v);
        acc_t ext;
        ext = acc_t'(v);
        return ext <<< Q9_FRAC;
    endfunction

endpackage

// File: rtl/mul_add_16q9_acc16.sv
// Combinational multiply-add-round-saturate: sum_o = a_i*x_i + addend_i (Q18),
// y_o = sum_o rounded to Q9 (ties toward zero) and clamped to 16 bits, sat_o = clamp hit.
import mac16_q9_pkg::*;

module mul_add_16q9_acc16 (
    input  q9_t        a_i,
    input  q9_t        x_i,
    input  acc_t       addend_i,
    output acc_t       sum_o,
    output q9_t        y_o,
    output logic       sat_o
);

    logic signed [31:0] prod;
    logic signed [27:0] rnd;
    logic               inc;

    always_comb begin
        prod  = a_i * x_i;
        sum_o = acc_t'(prod) + addend_i;

        // Exact ties (bit 8 set, lower bits clear) must not move a
        // positive value up; for negatives the arithmetic shift already
        // rounded down, so any half or more moves it back toward zero.
        if (sum_o[ACC_W-1]) begin
            inc = sum_o[8];
        end else begin
            inc = sum_o[8] & (|sum_o[7:0]);
        end
        rnd = {sum_o[ACC_W-1], sum_o[ACC_W-1:Q9_FRAC]} + {27'd0, inc};

        if (rnd > 28'sd32767) begin
            y_o   = Q9_MAX;
            sat_o = 1'b1;
        end else if (rnd < -28'sd32768) begin
            y_o   = Q9_MIN;
            sat_o = 1'b1;
        end else begin
            y_o   = rnd[DATA_W-1:0];
            sat_o = 1'b0;
        end
    end

endmodule

// File: rtl/mac16_q9_seq.sv
// Sequential Q9 dot-product engine: accumulates up to N_TERMS a*x products plus a
// per-vector bias, then presents one rounded/saturated result with valid/ready.
// Ports: clk_i, rst_i (sync, active high); input beat in_valid_i/in_ready_o/in_last_i,
// a_i, x_i, bias_i; result out_valid_o/out_ready_i, y_o (Q9), acc_o (raw Q18).
// Build option MAC16Q9_SAT_FLAG_EN adds sat_o, set when the result was clamped.
import mac16_q9_pkg::*;

module mac16_q9_seq #(
    parameter int N_TERMS = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        in_last_i,
    input  q9_t         a_i,
    input  q9_t         x_i,
    input  q9_t         bias_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output q9_t         y_o,
`ifdef MAC16Q9_SAT_FLAG_EN
    output logic        sat_o,
`endif
    output acc_t        acc_o
);

    localparam logic [4:0] N_TERMS_C = 5'(N_TERMS);

    state_e     state_q, state_d;
    logic [4:0] count_q, count_d;
    acc_t       acc_q, acc_d;
    acc_t       acc_out_q, acc_out_d;
    q9_t        y_q, y_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       sat_q, sat_d;

    acc_t       addend;
    acc_t       sum;
    q9_t        y_rnd;
    logic       sat_rnd;
    logic       first;
    logic       beat;
    logic       term;
    logic [4:0] count_inc;

    mul_add_16q9_acc16 u_mac (
        .a_i      (a_i),
        .x_i      (x_i),
        .addend_i (addend),
        .sum_o    (sum),
        .y_o      (y_rnd),
        .sat_o    (sat_rnd)
    );

    always_comb begin
        first     = (state_q == IDLE);
        beat      = in_valid_i & in_ready_q;
        addend    = first ? q9_to_acc(bias_i) : acc_q;
        count_inc = first ? 5'd1 : count_q + 5'd1;
        // A full vector ends itself even without in_last_i.
        term      = beat & (in_last_i | (count_inc == N_TERMS_C));

        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;

        unique case (state_q)
            IDLE, ACC: begin
                if (beat) begin
                    acc_d   = sum;
                    count_d = count_inc;
                    state_d = ACC;
                    if (term) begin
                        state_d     = OUT;
                        count_d     = 5'd0;
                        acc_out_d   = sum;
                        y_d         = y_rnd;
                        sat_d       = sat_rnd;
                        out_valid_d = 1'b1;
                    end
                end
            end
            OUT: begin
                if (out_valid_q & out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d != OUT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= 5'd0;
            acc_q       <= '0;
            acc_out_q   <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign y_o         = y_q;
    assign acc_o       = acc_out_q;

`ifdef MAC16Q9_SAT_FLAG_EN
    assign sat_o = sat_q;
`else
    logic sat_unused;
    assign sat_unused = sat_q;
`endif

endmodule

// File: tb/tb_mac16_q9_seq.sv
// Directed self-checking bench for mac16_q9_seq.
// Build option MAC16Q9_SAT_FLAG_EN also exercises sat_o.
module tb_mac16_q9_seq;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic signed [15:0] a = '0;
    logic signed [15:0] x = '0;
    logic signed [15:0] bias = '0;
    logic               out_ready = 1'b1;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] y;
    logic signed [35:0] acc;
`ifdef MAC16Q9_SAT_FLAG_EN
    logic               sat;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mac16_q9_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_last_i   (in_last),
        .a_i         (a),
        .x_i         (x),
        .bias_i      (bias),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
`ifdef MAC16Q9_SAT_FLAG_EN
        .sat_o       (sat),
`endif
        .acc_o       (acc)
    );

    // Drives one beat; returns #1 after the accepting edge.
    task automatic send(input logic signed [15:0] av,
                        input logic signed [15:0] xv,
                        input logic signed [15:0] bv,
                        input logic lv);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            checks++;
            failures++;
            $display("FAIL send_wait in_ready stuck low after %0d cycles", n);
        end
        in_valid = 1'b1;
        in_last  = lv;
        a = av;
        x = xv;
        bias = bv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || y !== 16'sd0 || acc !== 36'sd0) begin
            failures++;
            $display("FAIL reset_state got v=%b r=%b y=%0d acc=%0d want 0 0 0 0",
                     out_valid, in_ready, y, acc);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_single();
        send(16'sd512, 16'sd512, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== 36'sd262144 || y !== 16'sd512) begin
            failures++;
            $display("FAIL single got v=%b acc=%0d y=%0d want 1 262144 512",
                     out_valid, acc, y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_tie_round();
        send(16'sd1, 16'sd256, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (acc !== 36'sd256 || y !== 16'sd0) begin
            failures++;
            $display("FAIL tie_pos got acc=%0d y=%0d want 256 0", acc, y);
        end
        @(posedge clk); #1;
        send(-16'sd1, 16'sd256, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (acc !== -36'sd256 || y !== 16'sd0) begin
            failures++;
            $display("FAIL tie_neg got acc=%0d y=%0d want -256 0", acc, y);
        end
        @(posedge clk); #1;
        send(16'sd3, 16'sd256, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (acc !== 36'sd768 || y !== 16'sd1) begin
            failures++;
            $display("FAIL tie_odd got acc=%0d y=%0d want 768 1", acc, y);
        end
        @(posedge clk); #1;
        send(-16'sd3, 16'sd86, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (acc !== -36'sd258 || y !== -16'sd1) begin
            failures++;
            $display("FAIL round_neg got acc=%0d y=%0d want -258 -1", acc, y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_bias_terms();
        send(16'sd512, 16'sd256, 16'sd512, 1'b0);
        send(16'sd512, 16'sd256, 16'sd0, 1'b0);
        send(16'sd512, 16'sd256, 16'sd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bias_mid got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        send(16'sd512, 16'sd256, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== 36'sd786432 || y !== 16'sd1536) begin
            failures++;
            $display("FAIL bias_sum got v=%b acc=%0d y=%0d want 1 786432 1536",
                     out_valid, acc, y);
        end
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bias_out_ready got %b want 0", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 15; i++) send(16'sd32767, 16'sd32767, 16'sd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_15 got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        send(16'sd32767, 16'sd32767, 16'sd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== 36'sd17178820624 || y !== 16'sd32767) begin
            failures++;
            $display("FAIL sat_pos got v=%b acc=%0d y=%0d want 1 17178820624 32767",
                     out_valid, acc, y);
        end
`ifdef MAC16Q9_SAT_FLAG_EN
        checks++;
        if (sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_flag_pos got %b want 1", sat);
        end
`endif
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) send(16'sd32767, -16'sd32768, 16'sd0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== -36'sd17179344896 || y !== -16'sd32768) begin
            failures++;
            $display("FAIL sat_neg got v=%b acc=%0d y=%0d want 1 -17179344896 -32768",
                     out_valid, acc, y);
        end
`ifdef MAC16Q9_SAT_FLAG_EN
        checks++;
        if (sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_flag_neg got %b want 1", sat);
        end
`endif
        @(posedge clk); #1;
        // A fresh vector after forced termination must take its own bias.
        send(16'sd0, 16'sd0, 16'sd100, 1'b1);
        @(negedge clk);
        checks++;
        if (acc !== 36'sd51200 || y !== 16'sd100) begin
            failures++;
            $display("FAIL after_sat got acc=%0d y=%0d want 51200 100", acc, y);
        end
`ifdef MAC16Q9_SAT_FLAG_EN
        checks++;
        if (sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_flag_clear got %b want 0", sat);
        end
`endif
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(16'sd512, 16'sd512, 16'sd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || y !== 16'sd512 || acc !== 36'sd262144 ||
                in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b y=%0d acc=%0d r=%b want 1 512 262144 0",
                         i, out_valid, y, acc, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        send(16'sd1024, 16'sd512, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== 36'sd524288 || y !== 16'sd1024) begin
            failures++;
            $display("FAIL bp_next got v=%b acc=%0d y=%0d want 1 524288 1024",
                     out_valid, acc, y);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        send(16'sd512, 16'sd512, 16'sd512, 1'b0);
        send(16'sd512, 16'sd512, 16'sd0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || acc !== 36'sd0) begin
            failures++;
            $display("FAIL rst_mid got v=%b acc=%0d want 0 0", out_valid, acc);
        end
        @(posedge clk); #1;
        send(16'sd512, 16'sd512, 16'sd0, 1'b1);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || acc !== 36'sd262144 || y !== 16'sd512) begin
            failures++;
            $display("FAIL rst_resume got v=%b acc=%0d y=%0d want 1 262144 512",
                     out_valid, acc, y);
        end
        // Reset with a result pending drops it.
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_pending got v=%b want 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie_round();
        test_bias_terms();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac16_q9_seq.md
Name: mac16_q9_seq

Overview:
- Sequential dot-product engine for Q9 fixed-point (16-bit signed, 9 fractional bits).
- Accepts a stream of (a, x) coefficient/sample pairs plus a per-vector bias, and accumulates up to N_TERMS products in a 36-bit Q18 accumulator.
- Emits one rounded, saturated Q9 result per vector.
- Drives the team's combinational mul-add-round-saturate unit with its own registered accumulator as the addend.

Parameters:
- N_TERMS, 16, maximum products per vector; legal range 1..16, which keeps a 36-bit accumulator overflow-free.
- ACC_W, 36, accumulator width; fixed as 16 + 16 + clog2(16); not user-overridable.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block accepts an input beat
- in_last_i  in  1  final term of the current vector
- a_i  in  16  signed Q9 coefficient
- x_i  in  16  signed Q9 sample
- bias_i  in  16  signed Q9 bias; sampled only on the first beat of a vector
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream accepts result
- y_o  out  16  signed Q9 result, rounded and saturated
- acc_o  out  36  signed Q18 raw accumulator value (pre-round)

Behaviour:
- Reset state and outputs:
  - State IDLE, count 0, acc 0.
  - out_valid_o=0, y_o=0, acc_o=0, in_ready_o=0 during the reset cycle and 1 from the first cycle after.
- States:
  - IDLE → ACC on an accepted beat (in_valid_i & in_ready_o) without in_last_i.
  - IDLE → OUT on an accepted beat with in_last_i.
  - ACC → OUT on an accepted beat with in_last_i, or when count reaches N_TERMS.
  - ACC stays in ACC otherwise.
  - OUT → IDLE when out_valid_o & out_ready_i.
- in_ready_o = 1 in IDLE and ACC, 0 in OUT (no overlap between vectors).
- Arithmetic per accepted beat:
  - Addend is bias_i sign-extended to 36 bits and shifted left 9 on the first beat of a vector, otherwise the accumulator register.
  - acc_next = a_i*x_i (32-bit signed, Q18) + addend, in 36-bit signed arithmetic.
  - acc register updates on every accepted beat.
- Termination:
  - The beat that makes count == N_TERMS terminates the vector even if in_last_i=0.
  - The next accepted beat then starts a new vector and samples a new bias.
- Rounding of acc to Q9, ties toward zero:
  - Non-negative: add 1 at bit 9 if bit 8 = 1 and bits 7:0 ≠ 0.
  - Negative: add 1 at bit 9 if bit 8 = 1.
  - Result is 28-bit signed.
- Saturation: clamp the rounded value to [-32768, 32767]; y_o takes the clamped value.
- Result registers:
  - y_o and acc_o are registered on the terminating beat.
  - out_valid_o rises on the cycle after the terminating beat (latency 1).
- Hold and throughput:
  - y_o, acc_o and out_valid_o stay stable while out_valid_o & !out_ready_i.
  - Minimum vector period is terms + 1 cycles.
- in_valid_i=0 in ACC: the block waits; no timeout.
- Reset mid-vector: the partial accumulation is discarded and the block returns to IDLE next cycle; any pending out_valid_o is dropped.

Optional Feature:
- Macro MAC16Q9_SAT_FLAG_EN.
- Defined: adds output port sat_o (1 bit), registered alongside y_o. sat_o=1 if clamping occurred for the result; reset 0.
- Undefined: port absent; no change to any other behaviour.

Decomposition:
- Package mac16_q9_pkg holds:
  - Q9_FRAC=9, DATA_W=16, ACC_W=36.
  - Constants Q9_MAX=16'sh7FFF and Q9_MIN=16'sh8000.
  - typedef q9_t (logic signed [15:0]) and acc_t (logic signed [35:0]).
  - state_e enum {IDLE, ACC, OUT}.
- One sub-module: the existing combinational mul_add_16q9_acc16 performs multiply-add-round-saturate. It is instantiated once; this block adds control, bias selection, counting and result registers.

Test Plan:
- Single term: a=512, x=512, bias=0, last=1 → acc_o=262144, y_o=512, out_valid_o one cycle after the beat.
- Tie rounding: a=1, x=256, bias=0 → acc_o=256, y_o=0. Then a=-1, x=256 → acc_o=-256, y_o=0. Then a=3, x=256 → acc_o=768, y_o=1.
- Bias plus 4 terms: bias=512, four beats a=512, x=256 → acc_o=786432, y_o=1536; in_ready_o low during OUT.
- Saturation: 16 beats a=32767, x=32767, no last → forced termination after beat 16, y_o=32767 (sat_o=1 with flag). 16 beats a=32767, x=-32768 → y_o=-32768.
- Backpressure: out_ready_i low 3 cycles after out_valid_o → y_o/acc_o stable, in_ready_o=0; out_ready_i=1 → IDLE next cycle, next vector accepted.
- Reset mid-vector: rst_i asserted after 2 of 5 beats → out_valid_o=0, next vector (a=512, x=512, bias=0, last) gives y_o=512 with no residue.
